// File: rtl/alu_pkg.sv
// Shared decode constants and state encoding for the ALU and the iterative multiply/divide unit.
package alu_pkg;

    // R-type funct codes
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_JR    = 6'b001000;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    // ALU_Func encodings driven to the combinational ALU
    localparam logic [3:0] ALU_FUNC_AND  = 4'd0;
    localparam logic [3:0] ALU_FUNC_OR   = 4'd1;
    localparam logic [3:0] ALU_FUNC_ADD  = 4'd2;
    localparam logic [3:0] ALU_FUNC_SLL  = 4'd3;
    localparam logic [3:0] ALU_FUNC_SRL  = 4'd4;
    localparam logic [3:0] ALU_FUNC_SRA  = 4'd5;
    localparam logic [3:0] ALU_FUNC_SUB  = 4'd6;
    localparam logic [3:0] ALU_FUNC_SLT  = 4'd7;
    localparam logic [3:0] ALU_FUNC_SLTU = 4'd8;
    localparam logic [3:0] ALU_FUNC_XOR  = 4'd9;
    localparam logic [3:0] ALU_FUNC_NOR  = 4'd10;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} muldiv_state_t;

    function automatic logic is_muldiv_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_hilo_funct(input logic [5:0] f);
        return (f == FUNCT_MFHI) || (f == FUNCT_MTHI) || (f == FUNCT_MFLO) || (f == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/alu_muldiv_unit_datapath.sv
// One-bit-per-cycle shift-add multiply / restoring divide on unsigned magnitudes.
// acc holds {partial product high, multiplier} for mul and {remainder, quotient} for div.
module muldiv_iter_datapath #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step_mul,
    input  logic                 step_div,
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [WIDTH-1:0]     mag_b,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] diff;

    always_comb begin
        mul_addend = acc[0] ? operand_b : '0;
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        rem_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff       = {1'b0, rem_shift} - {2'b00, operand_b};
    end

    // A negative trial difference restores the shifted remainder and records a 0 quotient bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            operand_b <= '0;
        end else if (load) begin
            acc       <= {{WIDTH{1'b0}}, mag_a};
            operand_b <= mag_b;
        end else if (step_mul) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end else if (step_div) begin
            if (diff[WIDTH+1])
                acc <= {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Multiply/divide unit owning HI/LO: decode, FSM, sign handling and pipeline stall.
// Optional macro ALU_MULDIV_DIVZERO_TRAP_EN adds dz_err and short-circuits divide by zero.
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic             done,
`ifdef ALU_MULDIV_DIVZERO_TRAP_EN
    output logic             dz_err,
`endif
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t state, next_state;

    logic [CNT_W-1:0]   cnt;
    logic               div_mode;
    logic               neg_q;
    logic               neg_r;
    logic               dz_flag;
    logic               is_mul, is_div, is_signed;
    logic               start_mul, start_div, accept;
    logic               mthi_wr, mtlo_wr;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   q_res, r_res;

    always_comb begin
        is_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
        is_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
        is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
        start_mul = op_valid && is_mul && !busy;
        start_div = op_valid && is_div && !busy;
        accept    = start_mul || start_div;
        mthi_wr   = op_valid && (funct == FUNCT_MTHI) && !busy;
        mtlo_wr   = op_valid && (funct == FUNCT_MTLO) && !busy;
        stall     = op_valid && busy && (is_muldiv_funct(funct) || is_hilo_funct(funct));
        sign_a    = is_signed && rs_data[WIDTH-1];
        sign_b    = is_signed && rt_data[WIDTH-1];
        mag_a     = sign_a ? -rs_data : rs_data;
        mag_b     = sign_b ? -rt_data : rt_data;
        prod_res  = neg_q ? -acc : acc;
        q_res     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_res     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (funct == FUNCT_MFHI)
            rd_data = hi;
        else if (funct == FUNCT_MFLO)
            rd_data = lo;
        else
            rd_data = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_mul)
                    next_state = MUL;
                else if (start_div) begin
`ifdef ALU_MULDIV_DIVZERO_TRAP_EN
                    next_state = (rt_data == '0) ? FIX : DIV;
`else
                    next_state = DIV;
`endif
                end
            end
            MUL, DIV: begin
                if (cnt == CNT_W'(WIDTH - 1))
                    next_state = FIX;
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    muldiv_iter_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step_mul (state == MUL),
        .step_div (state == DIV),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .acc      (acc)
    );

    // Results are committed in FIX; divide by zero returns all-ones quotient and the dividend as remainder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_flag  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef ALU_MULDIV_DIVZERO_TRAP_EN
            dz_err   <= 1'b0;
`endif
        end else begin
            busy <= (next_state != IDLE);
            done <= (state == FIX);
`ifdef ALU_MULDIV_DIVZERO_TRAP_EN
            dz_err <= (state == FIX) && dz_flag;
`endif
            if (state == IDLE && accept) begin
                cnt      <= '0;
                div_mode <= start_div;
                neg_q    <= sign_a ^ sign_b;
                neg_r    <= sign_a;
                dz_flag  <= start_div && (rt_data == '0);
            end else if (state == MUL || state == DIV) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == FIX) begin
`ifdef ALU_MULDIV_DIVZERO_TRAP_EN
                if (!dz_flag) begin
                    if (div_mode) begin
                        lo <= q_res;
                        hi <= r_res;
                    end else begin
                        hi <= prod_res[2*WIDTH-1:WIDTH];
                        lo <= prod_res[WIDTH-1:0];
                    end
                end
`else
                if (div_mode) begin
                    lo <= dz_flag ? {WIDTH{1'b1}} : q_res;
                    hi <= r_res;
                end else begin
                    hi <= prod_res[2*WIDTH-1:WIDTH];
                    lo <= prod_res[WIDTH-1:0];
                end
`endif
            end else begin
                if (mthi_wr)
                    hi <= rs_data;
                if (mtlo_wr)
                    lo <= rs_data;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed self-checking bench for alu_muldiv_unit at WIDTH=32.
module tb_alu_muldiv_unit;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             op_valid;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef ALU_MULDIV_DIVZERO_TRAP_EN
    logic             dz_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .funct    (funct),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
`ifdef ALU_MULDIV_DIVZERO_TRAP_EN
        .dz_err   (dz_err),
`endif
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] f,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op_valid = v;
        funct    = f;
        rs_data  = a;
        rt_data  = b;
    endtask

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one op, then require done exactly WIDTH+1 edges after the accept edge
    task automatic runMuldiv(input string tag, input logic [5:0] f,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
        int early;
        early = 0;
        applyStimulus(1'b1, f, a, b);
        checkOutput({tag, "_stall_at_issue"}, WIDTH'(stall), 0);
        tick();
        applyStimulus(1'b0, FUNCT_SLL, '0, '0);
        checkOutput({tag, "_busy_after_accept"}, WIDTH'(busy), 1);
        repeat (WIDTH) begin
            tick();
            if (done) early++;
        end
        checkOutput({tag, "_early_done"}, early, 0);
        checkOutput({tag, "_busy_in_fix"}, WIDTH'(busy), 1);
        tick();
        checkOutput({tag, "_done"}, WIDTH'(done), 1);
        checkOutput({tag, "_hi"}, hi, exp_hi);
        checkOutput({tag, "_lo"}, lo, exp_lo);
        checkOutput({tag, "_busy_end"}, WIDTH'(busy), 0);
        tick();
        checkOutput({tag, "_done_single"}, WIDTH'(done), 0);
    endtask

    initial begin
        int miss;
        int pulses;
        logic [WIDTH-1:0] hold_hi;
        logic [WIDTH-1:0] hold_lo;

        rst_n = 1'b0;
        applyStimulus(1'b0, FUNCT_SLL, '0, '0);
        #12;
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        checkOutput("reset_busy", WIDTH'(busy), 0);
        checkOutput("reset_done", WIDTH'(done), 0);
        checkOutput("reset_stall", WIDTH'(stall), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        runMuldiv("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        runMuldiv("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runMuldiv("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runMuldiv("divu_basic", FUNCT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        runMuldiv("div_min_m1", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

`ifdef ALU_MULDIV_DIVZERO_TRAP_EN
        hold_hi = hi;
        hold_lo = lo;
        applyStimulus(1'b1, FUNCT_DIV, 32'd5, 32'd0);
        tick();
        applyStimulus(1'b0, FUNCT_SLL, '0, '0);
        checkOutput("dz_done_edge1", WIDTH'(done), 0);
        checkOutput("dz_busy_edge1", WIDTH'(busy), 1);
        tick();
        checkOutput("dz_done_edge2", WIDTH'(done), 1);
        checkOutput("dz_err_edge2", WIDTH'(dz_err), 1);
        checkOutput("dz_hi_kept", hi, hold_hi);
        checkOutput("dz_lo_kept", lo, hold_lo);
        tick();
        checkOutput("dz_err_clear", WIDTH'(dz_err), 0);
        checkOutput("dz_busy_clear", WIDTH'(busy), 0);
`else
        runMuldiv("div_by_zero", FUNCT_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
`endif

        hold_hi = hi;
        applyStimulus(1'b1, FUNCT_ADD, 32'd1, 32'd2);
        checkOutput("ignored_stall", WIDTH'(stall), 0);
        tick();
        checkOutput("ignored_busy", WIDTH'(busy), 0);
        checkOutput("ignored_hi", hi, hold_hi);

        // divu followed by mfhi that must be held until the unit returns to IDLE
        applyStimulus(1'b1, FUNCT_DIVU, 32'd100, 32'd7);
        tick();
        applyStimulus(1'b1, FUNCT_MFHI, '0, '0);
        miss = 0;
        checkOutput("mfhi_stall_first", WIDTH'(stall), 1);
        repeat (WIDTH) begin
            tick();
            if (stall !== 1'b1) miss++;
            if (done) miss++;
        end
        checkOutput("mfhi_stall_through_fix", miss, 0);
        tick();
        checkOutput("mfhi_stall_released", WIDTH'(stall), 0);
        checkOutput("mfhi_done", WIDTH'(done), 1);
        checkOutput("mfhi_rd_data", rd_data, 32'd2);
        tick();
        applyStimulus(1'b0, FUNCT_SLL, '0, '0);
        checkOutput("mfhi_no_restart", WIDTH'(busy), 0);

        applyStimulus(1'b1, FUNCT_MTHI, 32'h0000_1234, '0);
        tick();
        checkOutput("mthi_hi", hi, 32'h0000_1234);
        checkOutput("mthi_lo_kept", lo, 32'd14);
        applyStimulus(1'b1, FUNCT_MFHI, '0, '0);
        #1;
        checkOutput("mfhi_rd", rd_data, 32'h0000_1234);
        applyStimulus(1'b1, FUNCT_MFLO, '0, '0);
        #1;
        checkOutput("mflo_rd", rd_data, 32'd14);
        applyStimulus(1'b0, FUNCT_SLL, '0, '0);
        tick();

        // Reset in the middle of a multiply discards it
        applyStimulus(1'b1, FUNCT_MULT, 32'd5, 32'd6);
        tick();
        applyStimulus(1'b0, FUNCT_SLL, '0, '0);
        repeat (10) tick();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", WIDTH'(busy), 0);
        checkOutput("abort_hi", hi, 0);
        checkOutput("abort_lo", lo, 0);
        checkOutput("abort_done", WIDTH'(done), 0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            if (done) pulses++;
        end
        checkOutput("abort_no_done", pulses, 0);
        checkOutput("abort_idle", WIDTH'(busy), 0);
        runMuldiv("mult_after_abort", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
